// File: rtl/c_rb_pkg.sv
// Shared types and width helpers for the C-SRAM readback engine.
package c_rb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CV,
    REQ,
    OUT,
    DONE
  } rb_state_t;

  // Index width that stays at least one bit for degenerate 1-row/1-col tiles
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/c_sram_readback.sv
// Drains a finished C tile from the controller's CPU read port, one read in
// flight at a time, and streams each element out tagged with row/col/last.
module c_sram_readback
  import c_rb_pkg::*;
#(
  parameter int M       = 8,
  parameter int N       = 8,
  parameter int DATA_W  = 32,
  parameter int ROW_W   = idx_w(M),
  parameter int COL_W   = idx_w(N),
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              C_valid,
  output logic              cpu_c_en,
  output logic              cpu_c_re,
  output logic [ROW_W-1:0]  cpu_c_row,
  output logic [COL_W-1:0]  cpu_c_col,
  input  logic [DATA_W-1:0] cpu_c_rdata,
  input  logic              cpu_c_rvalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(N - 1);
  localparam logic [TW-1:0]    T_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  rb_state_t         state, state_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [COL_W-1:0]  col, col_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic              en_n, out_valid_n, out_last_n;
  logic [DATA_W-1:0] out_data_n;
  logic [ROW_W-1:0]  out_row_n;
  logic [COL_W-1:0]  out_col_n;
  logic              busy_n, done_n, err_n;
  logic              at_end, timed_out;

  assign at_end    = (row == ROW_MAX) && (col == COL_MAX);
  assign timed_out = (TIMEOUT > 0) && (tcnt == T_LAST);

  // The request address is the sweep counter itself, so it is registered and
  // naturally held stable for the whole REQ phase.
  assign cpu_c_row = row;
  assign cpu_c_col = col;
  assign cpu_c_re  = cpu_c_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      tcnt        <= '0;
      cpu_c_en    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_row     <= '0;
      out_col     <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      row         <= row_n;
      col         <= col_n;
      tcnt        <= tcnt_n;
      cpu_c_en    <= en_n;
      out_valid   <= out_valid_n;
      out_data    <= out_data_n;
      out_row     <= out_row_n;
      out_col     <= out_col_n;
      out_last    <= out_last_n;
      busy        <= busy_n;
      done        <= done_n;
      err_timeout <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = WAIT_CV;
      WAIT_CV: if (C_valid) state_n = REQ;
      REQ: begin
        if (cpu_c_rvalid)   state_n = OUT;
        else if (timed_out) state_n = DONE;
      end
      OUT:     if (out_ready) state_n = out_last ? DONE : REQ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of every registered output; en is raised on the same edge
  // that enters REQ so the request appears with no extra bubble.
  always_comb begin
    row_n       = row;
    col_n       = col;
    tcnt_n      = tcnt;
    en_n        = cpu_c_en;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_row_n   = out_row;
    out_col_n   = out_col;
    out_last_n  = out_last;
    err_n       = err_timeout;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          err_n = 1'b0;
          row_n = '0;
          col_n = '0;
        end
      end
      WAIT_CV: begin
        if (C_valid) begin
          en_n   = 1'b1;
          tcnt_n = '0;
        end
      end
      REQ: begin
        if (cpu_c_rvalid) begin
          en_n        = 1'b0;
          out_valid_n = 1'b1;
          out_data_n  = cpu_c_rdata;
          out_row_n   = row;
          out_col_n   = col;
          out_last_n  = at_end;
        end else if (timed_out) begin
          en_n   = 1'b0;
          err_n  = 1'b1;
          done_n = 1'b1;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
          if (out_last) begin
            done_n = 1'b1;
          end else begin
            en_n   = 1'b1;
            tcnt_n = '0;
            if (col == COL_MAX) begin
              col_n = '0;
              row_n = row + ROW_W'(1);
            end else begin
              col_n = col + COL_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_c_sram_readback.sv
// Scoreboard bench for c_sram_readback: expected beats are queued by the
// stimulus and popped by a monitor on every stream handshake.
module tb_c_sram_readback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        C_valid = 1'b0;
  logic        cpu_c_en, cpu_c_re;
  logic [2:0]  cpu_c_row, cpu_c_col;
  logic [31:0] cpu_c_rdata = '0;
  logic        cpu_c_rvalid = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  out_row, out_col;
  logic        out_last, busy, done, err_timeout;
  logic        resp_on = 1'b1;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_b;
  int checks = 0;
  int failures = 0;
  int beats = 0;
  int done_count = 0;

  c_sram_readback #(
    .M(8), .N(8), .DATA_W(32), .ROW_W(3), .COL_W(3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .C_valid(C_valid),
    .cpu_c_en(cpu_c_en), .cpu_c_re(cpu_c_re),
    .cpu_c_row(cpu_c_row), .cpu_c_col(cpu_c_col),
    .cpu_c_rdata(cpu_c_rdata), .cpu_c_rvalid(cpu_c_rvalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // One-cycle-latency SRAM model holding C[i][j] = 100*i + j
  always @(posedge clk) begin
    if (!rst) cpu_c_rvalid <= 1'b0;
    else      cpu_c_rvalid <= cpu_c_en && !cpu_c_rvalid && resp_on;
    cpu_c_rdata <= 32'(100 * cpu_c_row + cpu_c_col);
  end

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL beat_unexpected got data=%0d row=%0d col=%0d want none",
                 out_data, out_row, out_col);
      end else begin
        exp_b = exp_q.pop_front();
        if ({out_data, out_row, out_col, out_last} !== exp_b) begin
          failures++;
          $display("[TB] FAIL beat got data=%0d row=%0d col=%0d last=%0b want data=%0d row=%0d col=%0d last=%0b",
                   out_data, out_row, out_col, out_last,
                   exp_b.data, exp_b.row, exp_b.col, exp_b.last);
        end
      end
    end
    if (done) done_count++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_tile();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        exp_q.push_back('{32'(100 * i + j), 3'(i), 3'(j), (i == 7 && j == 7)});
  endtask

  task automatic apply_stimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs a drain to completion, optionally injecting a stray start or holding
  // off beat (2,3) for ten cycles, then checks beat/done accounting.
  task automatic run_until_done(input string name, input bit inject, input bit hold23);
    int d0 = done_count;
    int b0 = beats;
    bit injected = 1'b0;
    bit held = 1'b0;
    for (int cyc = 0; cyc < 3000 && done_count == d0; cyc++) begin
      tick();
      if (inject && !injected && beats >= 10) begin
        apply_stimulus();
        injected = 1'b1;
      end
      if (hold23 && !held && out_valid && out_row == 3'd2 && out_col == 3'd3) begin
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          tick();
          check_output("bp_data", out_data, 32'd203);
          check_output("bp_valid", 32'(out_valid), 32'd1);
          check_output("bp_en", 32'(cpu_c_en), 32'd0);
        end
        out_ready = 1'b1;
        held = 1'b1;
      end
    end
    repeat (4) tick();
    check_output({name, "_done_count"}, 32'(done_count - d0), 32'd1);
    check_output({name, "_beats"}, 32'(beats - b0), 32'd64);
    check_output({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check_output({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int d0, b0, en_cycles, bad;

    // Reset state
    repeat (3) tick();
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_en", 32'(cpu_c_en), 32'd0);
    check_output("rst_re", 32'(cpu_c_re), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err_timeout), 32'd0);
    check_output("rst_out_data", out_data, 32'd0);
    rst = 1'b1;
    tick();

    // Full drain with start latency check and a stray start at beat 10
    C_valid = 1'b1;
    push_tile();
    apply_stimulus();
    check_output("lat_en_t1", 32'(cpu_c_en), 32'd0);
    check_output("lat_busy_t1", 32'(busy), 32'd1);
    tick();
    check_output("lat_en_t2", 32'(cpu_c_en), 32'd1);
    check_output("lat_re_t2", 32'(cpu_c_re), 32'd1);
    run_until_done("full", 1'b1, 1'b0);
    check_output("full_err", 32'(err_timeout), 32'd0);

    // Backpressure on beat (2,3)
    push_tile();
    apply_stimulus();
    run_until_done("bp", 1'b0, 1'b1);

    // Start gated by C_valid
    C_valid = 1'b0;
    push_tile();
    apply_stimulus();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy !== 1'b1 || cpu_c_en !== 1'b0) bad++;
    end
    check_output("gate_bad_cycles", 32'(bad), 32'd0);
    C_valid = 1'b1;
    tick();
    check_output("gate_en", 32'(cpu_c_en), 32'd1);
    check_output("gate_row", 32'(cpu_c_row), 32'd0);
    check_output("gate_col", 32'(cpu_c_col), 32'd0);
    run_until_done("gate", 1'b0, 1'b0);

    // Timeout with a silent responder
    resp_on = 1'b0;
    d0 = done_count;
    b0 = beats;
    en_cycles = 0;
    apply_stimulus();
    for (int k = 0; k < 80 && done_count == d0; k++) begin
      tick();
      if (cpu_c_en) en_cycles++;
    end
    repeat (3) tick();
    check_output("to_en_cycles", 32'(en_cycles), 32'd16);
    check_output("to_err", 32'(err_timeout), 32'd1);
    check_output("to_done_count", 32'(done_count - d0), 32'd1);
    check_output("to_beats", 32'(beats - b0), 32'd0);
    check_output("to_busy", 32'(busy), 32'd0);
    resp_on = 1'b1;
    push_tile();
    apply_stimulus();
    check_output("to_err_cleared", 32'(err_timeout), 32'd0);
    run_until_done("after_to", 1'b0, 1'b0);

    // Reset while beat (4,5) waits in OUT
    push_tile();
    d0 = done_count;
    apply_stimulus();
    bad = 1;
    for (int k = 0; k < 3000 && bad == 1; k++) begin
      tick();
      if (out_valid && out_row == 3'd4 && out_col == 3'd5) begin
        out_ready = 1'b0;
        bad = 0;
      end
    end
    check_output("mid_reached_45", 32'(bad), 32'd0);
    rst = 1'b0;
    tick();
    check_output("mid_out_valid", 32'(out_valid), 32'd0);
    check_output("mid_en", 32'(cpu_c_en), 32'd0);
    check_output("mid_busy", 32'(busy), 32'd0);
    check_output("mid_out_data", out_data, 32'd0);
    rst = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    repeat (5) tick();
    check_output("mid_no_done", 32'(done_count - d0), 32'd0);
    push_tile();
    apply_stimulus();
    run_until_done("mid_restart", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
